// File: rtl/decode_stage_pkg.sv
// Shared types and instruction-field positions for the decode stage.
// Optional build macro DECODE_ILLEGAL_TRAP_EN (illegal opcodes trap) is
// consumed by decode_stage_if.sv and decode_stage.sv.
package decode_stage_pkg;

  // Jump condition encoding, shared with the program counter.
  typedef enum logic [1:0] {
    JMP = 2'b00,
    JZ  = 2'b01,
    JNZ = 2'b10,
    JL  = 2'b11
  } jump_t;

  // Opcode landmarks; 0x1..0x7 is the ALU range, the rest of the gaps are illegal.
  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ALU_LO = 4'h1,
    OP_ALU_HI = 4'h7,
    OP_JUMP   = 4'h8,
    OP_HALT   = 4'hF
  } op_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SQUASH,
    ST_HALTED
  } dstate_t;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int COND_MSB = 9;
  localparam int COND_LSB = 8;
  localparam int OPND_MSB = 11;
  localparam int ALU_MSB  = 14;

  function automatic logic is_alu_op(input logic [3:0] opc);
    return (opc >= OP_ALU_LO) && (opc <= OP_ALU_HI);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus between instruction ROM / ALU / PC and the decode stage.
// With DECODE_ILLEGAL_TRAP_EN defined the bus carries an extra trap pulse.
interface decode_stage_if #(
  parameter int A_WIDTH = 8,
  parameter int I_WIDTH = 16
);
  import decode_stage_pkg::*;

  logic [I_WIDTH-1:0] instr;
  logic [A_WIDTH-1:0] pc_addr;
  logic               alu_z;
  logic               alu_s;
  logic               alu_o;

  logic               op_valid;
  logic [2:0]         alu_op;
  logic [11:0]        operand;
  logic               is_jump;
  jump_t              jump_cond;
  logic [A_WIDTH-1:0] jump_addr;
  logic               flag_z;
  logic               flag_s;
  logic               flag_o;
  logic               halted;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic               trap;
`endif

  // Environment side: ROM, ALU and PC.
  modport master (
    output instr, pc_addr, alu_z, alu_s, alu_o,
`ifdef DECODE_ILLEGAL_TRAP_EN
    input  trap,
`endif
    input  op_valid, alu_op, operand, is_jump, jump_cond, jump_addr,
           flag_z, flag_s, flag_o, halted
  );

  // Decode stage side.
  modport slave (
    input  instr, pc_addr, alu_z, alu_s, alu_o,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output trap,
`endif
    output op_valid, alu_op, operand, is_jump, jump_cond, jump_addr,
           flag_z, flag_s, flag_o, halted
  );

endinterface

// File: rtl/decode_stage_jump_eval.sv
// Combinational jump-taken evaluator; the PC uses the identical rule.
module jump_eval
  import decode_stage_pkg::*;
(
  input  jump_t i_cond,
  input  logic  i_z,
  input  logic  i_s,
  input  logic  i_o,
  output logic  o_taken
);

  // Map the condition code onto the registered flags.
  always_comb begin
    // NOTE: default assignment first so no path leaves o_taken unassigned (no latch).
    o_taken = 1'b0;
    case (i_cond)
      JMP:     o_taken = 1'b1;
      JZ:      o_taken = i_z;
      JNZ:     o_taken = ~i_z;
      JL:      o_taken = i_s | i_o;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction register and decode stage feeding the ALU and the PC.
// Holds the Z/S/O flag register, squashes the branch shadow after a taken
// jump and implements HALT. Define DECODE_ILLEGAL_TRAP_EN to make illegal
// opcodes jump to TRAP_ADDR and pulse trap; otherwise they decode as NOP.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int I_WIDTH = 16
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  parameter logic [7:0] TRAP_ADDR = 8'hF0
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_stage_if.slave  bus
);

  logic [I_WIDTH-1:0] r_ir;
  logic [A_WIDTH-1:0] r_ir_addr;
  logic               r_ir_valid;
  dstate_t            r_state;
  logic               r_flag_z;
  logic               r_flag_s;
  logic               r_flag_o;

  logic [3:0]         w_opcode;
  jump_t              w_cond;
  logic               w_taken;
  dstate_t            w_next_state;
  logic               w_flag_we;
  logic               w_hold_ir;

  assign w_opcode = r_ir[OPC_MSB:OPC_LSB];
  assign w_cond   = jump_t'(r_ir[COND_MSB:COND_LSB]);

  jump_eval u_jump_eval (
    .i_cond  (w_cond),
    .i_z     (r_flag_z),
    .i_s     (r_flag_s),
    .i_o     (r_flag_o),
    .o_taken (w_taken)
  );

  assign bus.alu_op  = r_ir[ALU_MSB:OPC_LSB];
  assign bus.operand = r_ir[OPND_MSB:0];
  assign bus.flag_z  = r_flag_z;
  assign bus.flag_s  = r_flag_s;
  assign bus.flag_o  = r_flag_o;

  // IR must keep the HALT word (and its address) from the HALT cycle onwards,
  // otherwise the branch-shadow fetch would overwrite the halt address.
  assign w_hold_ir = (r_state == ST_HALTED) || (w_next_state == ST_HALTED);

  // Decode IR under the current state into ALU/PC controls and the next state.
  always_comb begin
    bus.op_valid  = 1'b0;
    bus.is_jump   = 1'b0;
    bus.jump_cond = JMP;
    bus.jump_addr = '0;
    bus.halted    = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    bus.trap      = 1'b0;
`endif
    w_flag_we     = 1'b0;
    w_next_state  = r_state;
    case (r_state)
      ST_RUN: begin
        if (r_ir_valid) begin
          if (is_alu_op(w_opcode)) begin
            bus.op_valid = 1'b1;
            w_flag_we    = 1'b1;
          end else if (w_opcode == OP_JUMP) begin
            bus.is_jump   = 1'b1;
            bus.jump_cond = w_cond;
            bus.jump_addr = r_ir[A_WIDTH-1:0];
            if (w_taken) w_next_state = ST_SQUASH;
          end else if (w_opcode == OP_HALT) begin
            bus.is_jump   = 1'b1;
            bus.jump_addr = r_ir_addr;
            w_next_state  = ST_HALTED;
          end
`ifdef DECODE_ILLEGAL_TRAP_EN
          else if (w_opcode != OP_NOP) begin
            bus.is_jump   = 1'b1;
            bus.jump_addr = TRAP_ADDR[A_WIDTH-1:0];
            bus.trap      = 1'b1;
            w_next_state  = ST_SQUASH;
          end
`endif
        end
      end
      ST_SQUASH: w_next_state = ST_RUN;
      ST_HALTED: begin
        bus.is_jump   = 1'b1;
        bus.jump_addr = r_ir_addr;
        bus.halted    = 1'b1;
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  // Instruction register, state and flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir       <= '0;
      r_ir_addr  <= '0;
      r_ir_valid <= 1'b0;
      r_state    <= ST_RUN;
      r_flag_z   <= 1'b0;
      r_flag_s   <= 1'b0;
      r_flag_o   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_state <= w_next_state;
      if (!w_hold_ir) begin
        r_ir       <= bus.instr;
        r_ir_addr  <= bus.pc_addr;
        r_ir_valid <= 1'b1;
      end
      if (w_flag_we) begin
        r_flag_z <= bus.alu_z;
        r_flag_s <= bus.alu_s;
        r_flag_o <= bus.alu_o;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a random
// program, all compared every cycle against an instruction-level model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  decode_stage_if #(.A_WIDTH(AW), .I_WIDTH(16)) bus ();

  decode_stage #(.A_WIDTH(AW), .I_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rom [256];

  // Instruction-level model: what sits in IR, whether it is a dead shadow slot,
  // whether the core is halted, the flag register and the PC presented to ROM.
  logic [15:0] m_ir;
  logic [7:0]  m_addr;
  logic        m_valid, m_squash, m_halt;
  logic [2:0]  m_flags;
  logic [7:0]  m_pc;

  // Expected outputs for the current cycle.
  logic       e_opv, e_jump, e_halted, e_trap, e_take, e_enter_halt, e_alu;
  logic [1:0] e_cond;
  logic [7:0] e_addr;

  task automatic model_outputs();
    int opc;
    opc = int'(m_ir[15:12]);
    e_opv = 0; e_jump = 0; e_halted = 0; e_trap = 0; e_take = 0;
    e_enter_halt = 0; e_alu = 0; e_cond = 2'b00; e_addr = 8'h00;
    if (m_halt) begin
      e_jump = 1; e_addr = m_addr; e_halted = 1; e_take = 1;
    end else if (m_valid && !m_squash) begin
      if (opc >= 1 && opc <= 7) begin
        e_opv = 1; e_alu = 1;
      end else if (opc == 8) begin
        e_jump = 1; e_cond = m_ir[9:8]; e_addr = m_ir[7:0];
        if (e_cond == 2'd0)      e_take = 1;
        else if (e_cond == 2'd1) e_take = m_flags[2];
        else if (e_cond == 2'd2) e_take = !m_flags[2];
        else                     e_take = m_flags[1] || m_flags[0];
      end else if (opc == 15) begin
        e_jump = 1; e_addr = m_addr; e_take = 1; e_enter_halt = 1;
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      else if (opc != 0) begin
        e_jump = 1; e_addr = 8'hF0; e_take = 1; e_trap = 1;
      end
`endif
    end
  endtask

  task automatic drive_pc();
    bus.pc_addr = m_pc;
    bus.instr   = rom[m_pc];
  endtask

  // One clock: present ALU flags, compare at negedge, advance model at posedge.
  // Called at posedge+1 (or reset-release time); returns at posedge+1.
  task automatic step(input logic [2:0] zso);
    {bus.alu_z, bus.alu_s, bus.alu_o} = zso;
    @(negedge clk);
    model_outputs();
    n_checks++; if (bus.op_valid !== e_opv) begin n_fail++; $display("FAIL op_valid @%0h: got %b want %b", m_addr, bus.op_valid, e_opv); end
    n_checks++; if (bus.alu_op !== m_ir[14:12]) begin n_fail++; $display("FAIL alu_op @%0h: got %0h want %0h", m_addr, bus.alu_op, m_ir[14:12]); end
    n_checks++; if (bus.operand !== m_ir[11:0]) begin n_fail++; $display("FAIL operand @%0h: got %0h want %0h", m_addr, bus.operand, m_ir[11:0]); end
    n_checks++; if (bus.is_jump !== e_jump) begin n_fail++; $display("FAIL is_jump @%0h: got %b want %b", m_addr, bus.is_jump, e_jump); end
    n_checks++; if (bus.jump_cond !== e_cond) begin n_fail++; $display("FAIL jump_cond @%0h: got %0d want %0d", m_addr, bus.jump_cond, e_cond); end
    n_checks++; if (bus.jump_addr !== e_addr) begin n_fail++; $display("FAIL jump_addr @%0h: got %0h want %0h", m_addr, bus.jump_addr, e_addr); end
    n_checks++; if ({bus.flag_z, bus.flag_s, bus.flag_o} !== m_flags) begin n_fail++; $display("FAIL flags @%0h: got %b want %b", m_addr, {bus.flag_z, bus.flag_s, bus.flag_o}, m_flags); end
    n_checks++; if (bus.halted !== e_halted) begin n_fail++; $display("FAIL halted @%0h: got %b want %b", m_addr, bus.halted, e_halted); end
`ifdef DECODE_ILLEGAL_TRAP_EN
    n_checks++; if (bus.trap !== e_trap) begin n_fail++; $display("FAIL trap @%0h: got %b want %b", m_addr, bus.trap, e_trap); end
`endif
    @(posedge clk);
    #1;
    if (e_alu) m_flags = zso;
    if (!(m_halt || e_enter_halt)) begin
      m_ir = rom[m_pc]; m_addr = m_pc; m_valid = 1;
    end
    m_squash = e_take && !m_halt && !e_enter_halt;
    m_halt   = m_halt || e_enter_halt;
    m_pc     = e_take ? e_addr : m_pc + 8'd1;
    drive_pc();
  endtask

  // Called at posedge+1; asserts reset mid-cycle and resets the model.
  task automatic assert_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m_ir = '0; m_addr = '0; m_valid = 0; m_squash = 0; m_halt = 0;
    m_flags = '0; m_pc = '0;
    drive_pc();
    {bus.alu_z, bus.alu_s, bus.alu_o} = 3'b000;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({bus.op_valid, bus.alu_op, bus.operand, bus.is_jump, bus.jump_cond, bus.jump_addr,
         bus.flag_z, bus.flag_s, bus.flag_o, bus.halted} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs-zero: got op_valid=%b alu_op=%0h operand=%0h is_jump=%b cond=%0d addr=%0h flags=%b halted=%b, want all 0",
               tag, bus.op_valid, bus.alu_op, bus.operand, bus.is_jump, bus.jump_cond, bus.jump_addr,
               {bus.flag_z, bus.flag_s, bus.flag_o}, bus.halted);
    end
  endtask

  task automatic fill_alu(input int hi);
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    for (int a = 0; a <= hi; a++) rom[a] = {1'b0, 3'($urandom_range(1, 7)), 12'($urandom)};
  endtask

  task automatic test_reset();
    fill_alu(10);
    assert_reset();
    check_all_zero("reset");
    release_reset();
    step(3'b000);
    n_checks++; if (bus.op_valid !== 1'b1) begin n_fail++; $display("FAIL first_decode: op_valid got %b want 1", bus.op_valid); end
  endtask

  task automatic test_alu_seq();
    fill_alu(10);
    rom[0] = 16'h1000; rom[1] = 16'h2000; rom[2] = 16'h0000;
    assert_reset(); release_reset();
    step(3'b000);
    n_checks++; if ({bus.op_valid, bus.alu_op, bus.is_jump} !== {1'b1, 3'd1, 1'b0}) begin n_fail++; $display("FAIL alu_seq0: got %b/%0d/%b want 1/1/0", bus.op_valid, bus.alu_op, bus.is_jump); end
    step(3'b100);
    n_checks++; if ({bus.op_valid, bus.alu_op, bus.flag_z, bus.flag_s, bus.flag_o} !== {1'b1, 3'd2, 3'b100}) begin n_fail++; $display("FAIL alu_seq1: got %b/%0d/%b%b%b want 1/2/100", bus.op_valid, bus.alu_op, bus.flag_z, bus.flag_s, bus.flag_o); end
    step(3'b010);
    n_checks++; if ({bus.op_valid, bus.alu_op, bus.is_jump, bus.flag_z, bus.flag_s, bus.flag_o} !== {1'b0, 3'd0, 1'b0, 3'b010}) begin n_fail++; $display("FAIL alu_seq_nop: got %b/%0d/%b/%b%b%b want 0/0/0/010", bus.op_valid, bus.alu_op, bus.is_jump, bus.flag_z, bus.flag_s, bus.flag_o); end
    step(3'b111);
  endtask

  task automatic test_jz_taken();
    fill_alu(4);
    rom[5] = 16'h8120; rom[6] = 16'h1ABC; rom[8'h20] = 16'h2345; rom[8'h21] = 16'h3000;
    assert_reset(); release_reset();
    for (int i = 0; i < 6; i++) step(3'b100);
    n_checks++; if ({bus.is_jump, bus.jump_cond, bus.jump_addr} !== {1'b1, JZ, 8'h20}) begin n_fail++; $display("FAIL jz_taken: got %b/%0d/%0h want 1/1/20", bus.is_jump, bus.jump_cond, bus.jump_addr); end
    step(3'b011);
    n_checks++; if ({bus.op_valid, bus.is_jump} !== 2'b00) begin n_fail++; $display("FAIL jz_shadow: got op_valid=%b is_jump=%b want 0/0", bus.op_valid, bus.is_jump); end
    step(3'b011);
    n_checks++; if ({bus.op_valid, bus.alu_op, bus.flag_z, bus.flag_s, bus.flag_o} !== {1'b1, 3'd2, 3'b100}) begin n_fail++; $display("FAIL jz_target: got %b/%0d/%b%b%b want 1/2/100", bus.op_valid, bus.alu_op, bus.flag_z, bus.flag_s, bus.flag_o); end
    step(3'b000);
  endtask

  task automatic test_untaken_and_jl();
    fill_alu(4);
    rom[5] = 16'h8120; rom[6] = 16'h1000; rom[7] = 16'h8340; rom[8] = 16'h5555; rom[8'h40] = 16'h6000;
    assert_reset(); release_reset();
    for (int i = 0; i < 6; i++) step(3'b001);
    n_checks++; if ({bus.is_jump, bus.jump_cond} !== {1'b1, JZ}) begin n_fail++; $display("FAIL jz_untaken: got %b/%0d want 1/1", bus.is_jump, bus.jump_cond); end
    step(3'b001);
    n_checks++; if ({bus.op_valid, bus.alu_op} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL jz_fallthrough: got %b/%0d want 1/1", bus.op_valid, bus.alu_op); end
    step(3'b001);
    n_checks++; if ({bus.is_jump, bus.jump_cond, bus.jump_addr} !== {1'b1, JL, 8'h40}) begin n_fail++; $display("FAIL jl: got %b/%0d/%0h want 1/3/40", bus.is_jump, bus.jump_cond, bus.jump_addr); end
    step(3'b000);
    n_checks++; if (bus.op_valid !== 1'b0) begin n_fail++; $display("FAIL jl_shadow: op_valid got %b want 0", bus.op_valid); end
    step(3'b000);
    n_checks++; if ({bus.op_valid, bus.alu_op} !== {1'b1, 3'd6}) begin n_fail++; $display("FAIL jl_target: got %b/%0d want 1/6", bus.op_valid, bus.alu_op); end
  endtask

  task automatic test_reset_in_squash();
    int budget;
    fill_alu(4);
    rom[5] = 16'h8010;
    assert_reset(); release_reset();
    budget = 0;
    while (!m_squash && budget < 20) begin step(3'($urandom)); budget++; end
    n_checks++; if (!m_squash) begin n_fail++; $display("FAIL squash_reach: squash slot not reached within %0d cycles", budget); end
    assert_reset();
    check_all_zero("reset_squash");
    release_reset();
    step(3'b000);
    n_checks++; if ({bus.op_valid, bus.alu_op} !== {1'b1, rom[0][14:12]}) begin n_fail++; $display("FAIL squash_resume: got %b/%0d want 1/%0d", bus.op_valid, bus.alu_op, rom[0][14:12]); end
  endtask

  task automatic test_halt();
    logic [2:0] held;
    fill_alu(8'h11);
    rom[8'h12] = 16'hF000; rom[8'h13] = 16'h1000;
    assert_reset(); release_reset();
    for (int i = 0; i < 19; i++) step(3'($urandom));
    held = {bus.flag_z, bus.flag_s, bus.flag_o};
    n_checks++; if ({bus.is_jump, bus.jump_cond, bus.jump_addr, bus.halted} !== {1'b1, JMP, 8'h12, 1'b0}) begin n_fail++; $display("FAIL halt_decode: got %b/%0d/%0h/%b want 1/0/12/0", bus.is_jump, bus.jump_cond, bus.jump_addr, bus.halted); end
    for (int i = 0; i < 5; i++) begin
      step(~held);
      n_checks++;
      if ({bus.halted, bus.is_jump, bus.jump_addr, bus.op_valid, bus.flag_z, bus.flag_s, bus.flag_o} !== {1'b1, 1'b1, 8'h12, 1'b0, held}) begin
        n_fail++;
        $display("FAIL halted_hold: got halted=%b is_jump=%b addr=%0h op_valid=%b flags=%b want 1/1/12/0/%b",
                 bus.halted, bus.is_jump, bus.jump_addr, bus.op_valid, {bus.flag_z, bus.flag_s, bus.flag_o}, held);
      end
    end
    assert_reset();
    check_all_zero("reset_halted");
    release_reset();
    step(3'b000);
    n_checks++; if ({bus.op_valid, bus.halted} !== 2'b10) begin n_fail++; $display("FAIL halt_resume: got op_valid=%b halted=%b want 1/0", bus.op_valid, bus.halted); end
  endtask

  task automatic test_illegal();
    fill_alu(4);
    rom[0] = 16'hA123; rom[1] = 16'h1000; rom[8'hF0] = 16'h2000;
    assert_reset(); release_reset();
    step(3'b000);
`ifdef DECODE_ILLEGAL_TRAP_EN
    n_checks++; if ({bus.trap, bus.is_jump, bus.jump_addr} !== {1'b1, 1'b1, 8'hF0}) begin n_fail++; $display("FAIL trap: got %b/%b/%0h want 1/1/f0", bus.trap, bus.is_jump, bus.jump_addr); end
    step(3'b000);
    n_checks++; if ({bus.op_valid, bus.trap} !== 2'b00) begin n_fail++; $display("FAIL trap_shadow: got %b/%b want 0/0", bus.op_valid, bus.trap); end
    step(3'b000);
    n_checks++; if ({bus.op_valid, bus.alu_op} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL trap_vector: got %b/%0d want 1/2", bus.op_valid, bus.alu_op); end
`else
    n_checks++; if ({bus.op_valid, bus.is_jump} !== 2'b00) begin n_fail++; $display("FAIL illegal_nop: got %b/%b want 0/0", bus.op_valid, bus.is_jump); end
    step(3'b000);
    n_checks++; if ({bus.op_valid, bus.alu_op} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL illegal_next: got %b/%0d want 1/1", bus.op_valid, bus.alu_op); end
`endif
  endtask

  task automatic test_random();
    int r;
    for (int a = 0; a < 256; a++) begin
      r = $urandom_range(0, 15);
      if (r <= 6)       rom[a] = {1'b0, 3'($urandom_range(1, 7)), 12'($urandom)};
      else if (r <= 9)  rom[a] = {4'h8, 2'b00, 2'($urandom), 8'($urandom)};
      else if (r <= 12) rom[a] = {4'($urandom_range(9, 14)), 12'($urandom)};
      else              rom[a] = 16'h0000;
    end
    assert_reset(); release_reset();
    for (int i = 0; i < 400; i++) step(3'($urandom));
  endtask

  initial begin
    bus.instr = '0; bus.pc_addr = '0;
    bus.alu_z = 1'b0; bus.alu_s = 1'b0; bus.alu_o = 1'b0;
    test_reset();
    test_alu_seq();
    test_jz_taken();
    test_untaken_and_jl();
    test_reset_in_squash();
    test_halt();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
